uart_fifo_bridge: RTL and testbench
===================================

UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 Parameter DEPTH, default 16, entries per FIFO (power of 2, >=2); CW = log2(DEPTH)+1 count width.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 address_in  in  64  CPU register select; only [3:2] decoded: 00 STATUS, 01 DATA, 10 CLK_DIV, 11 reserved.
REQ-005 sel_in  in  1  CPU access strobe; read_in  in  1  CPU read qualifier.
REQ-006 write_mask_in  in  4  CPU write byte-pair enables; write_value_in  in  64  CPU write data.
REQ-007 read_value_out  out  64  CPU read data, combinational.
REQ-008 uart_address_out  out  64  master address to uart (0x0 CLK_DIV, 0x4 STATUS, 0x8 DATA).
REQ-009 uart_sel_out, uart_read_out  out  1 each; uart_write_mask_out  out  4; uart_write_value_out  out  64.
REQ-010 uart_read_value_in  in  64  uart combinational read data (STATUS bit0 tx_ready, bit1 rx_ready; DATA [15:0] word).

Function
REQ-011 Two 16-bit FIFOs: TXQ (CPU->uart), RXQ (uart->CPU), each DEPTH entries, pointer wrap modulo DEPTH, counts 0..DEPTH.
REQ-012 CPU read (sel_in=1, combinational): STATUS = {43'b0, rx_cnt[CW-1:0] at [20:16], tx_cnt at [12:8], ovf at [3], rxq_nonempty at [1], txq_notfull at [0]} (unused bits zero); DATA = {48'b0, RXQ head} if RXQ nonempty else {48'hFFFF_FFFF_FFFF, 16'b0}; CLK_DIV = {32'b0, shadow clk_div}; reserved = 0; sel_in=0 -> 0.
REQ-013 CPU DATA read with read_in=1 and RXQ nonempty pops RXQ at that edge; when RXQ empty, no state change.
REQ-014 CPU DATA write with write_mask_in[0]=1 pushes write_value_in[15:0] into TXQ; when TXQ full, word dropped and ovf set to 1.
REQ-015 CPU STATUS write with write_mask_in[0]=1 clears ovf; clear and new overflow in same cycle -> ovf=1.
REQ-016 CPU CLK_DIV write updates shadow clk_div per mask ([1]->[31:16], [0]->[15:0]) and sets cfg_pending.
REQ-017 Master FSM states IDLE, CFG, POLL, RX, TX; exactly one uart access per non-IDLE cycle; IDLE drives all uart outputs 0.
REQ-018 IDLE -> CFG if cfg_pending, else -> POLL.
REQ-019 CFG: sel=1, addr 0x0, write_mask 4'b0011, value {32'b0, clk_div}; clear cfg_pending unless CPU writes CLK_DIV same cycle; -> IDLE.
REQ-020 POLL: sel=1, addr 0x4, read=0, mask 0; sample status; -> RX if rx_ready and RXQ not full; else -> TX if tx_ready and TXQ nonempty; else -> IDLE.
REQ-021 RX: sel=1, addr 0x8, read=1, mask 0; push uart_read_value_in[15:0] into RXQ; -> IDLE.
REQ-022 TX: sel=1, addr 0x8, read=0, mask 4'b0001, value {48'b0, TXQ head}; pop TXQ; -> IDLE.
REQ-023 Simultaneous CPU push and FSM pop on TXQ (or FSM push and CPU pop on RXQ): both take effect, count unchanged; on full FIFO a same-cycle pop makes the push legal.
REQ-024 RX priority over TX; uart rx data held in uart while RXQ full (no loss in bridge).
REQ-025 Minimum 3-cycle loop (IDLE, POLL, RX/TX) guarantees uart status reflects prior write before next poll.

Reset
REQ-026 On reset: FSM IDLE, both FIFOs empty, pointers 0, ovf=0, cfg_pending=0, clk_div shadow=0, all uart_* outputs 0.
REQ-027 Reset mid-transfer abandons FSM state and discards FIFO contents; uart receives no access the cycle after reset asserts.
REQ-028 Reset dominates all same-cycle CPU accesses.

Verification
REQ-029 Reset, then CPU read STATUS -> 0x0000_0001 (txq_notfull only); DATA read -> 0xFFFF_FFFF_FFFF_0000.
REQ-030 CPU write CLK_DIV 0x0000_0064 mask 4'b0011 -> within 2 cycles one uart write addr 0x0 value 0x64 mask 4'b0011.
REQ-031 Uart model tx_ready=1; CPU pushes 0x0041, 0x0042 -> uart DATA writes 0x0041 then 0x0042 in order, TX states >=3 cycles apart.
REQ-032 Push DEPTH+1 words with tx_ready=0 -> tx_cnt=DEPTH, ovf=1, extra word absent; STATUS write mask 0001 -> ovf=0.
REQ-033 Uart model rx_ready=1 data 0x1234 -> RXQ count 1, CPU DATA read returns 0x0000_0000_0000_1234, next read returns empty pattern.
REQ-034 rx_ready and tx_ready both 1 with TXQ nonempty -> RX access precedes TX access; reset asserted during TX state -> uart outputs 0 next cycle, counts 0.

Source files
------------

// File: rtl/uart_fifo_bridge_if.sv
// Simple register bus: one access per cycle, read data returned combinationally.
interface uart_fifo_bridge_if;
  logic [63:0] address;
  logic        sel;
  logic        read;
  logic [3:0]  write_mask;
  logic [63:0] write_value;
  logic [63:0] read_value;

  modport master (
    output address, sel, read, write_mask, write_value,
    input  read_value
  );

  modport slave (
    input  address, sel, read, write_mask, write_value,
    output read_value
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// CPU-facing register block with TX/RX word FIFOs, plus a master FSM that polls,
// configures and moves words to/from a UART over a second register bus.
module uart_fifo_bridge #(
  parameter int unsigned DEPTH = 16
) (
  input logic                clk,
  input logic                reset,
  uart_fifo_bridge_if.slave  cpu_bus,
  uart_fifo_bridge_if.master uart_bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StCfg, StPoll, StRx, StTx} state_e;

  state_e state_q, state_d;

  logic [15:0]   txq_mem_q [DEPTH];
  logic [15:0]   rxq_mem_q [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          ovf_q, ovf_d;
  logic          cfg_pending_q, cfg_pending_d;
  logic [31:0]   clk_div_q, clk_div_d;

  logic [1:0]  reg_sel;
  logic        cpu_wr, data_wr, status_wr, div_wr, data_rd;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop, ovf_set, cfg_clear;
  logic [63:0] rd_data;

  logic [63:0] u_addr, u_val;
  logic        u_sel, u_read;
  logic [3:0]  u_mask;

  assign reg_sel   = cpu_bus.address[3:2];
  assign cpu_wr    = cpu_bus.sel & ~cpu_bus.read;
  assign data_wr   = cpu_wr & (reg_sel == 2'b01) & cpu_bus.write_mask[0];
  assign status_wr = cpu_wr & (reg_sel == 2'b00) & cpu_bus.write_mask[0];
  assign div_wr    = cpu_wr & (reg_sel == 2'b10) & (|cpu_bus.write_mask[1:0]);
  assign data_rd   = cpu_bus.sel & cpu_bus.read & (reg_sel == 2'b01);

  assign tx_full  = (tx_cnt_q == Full);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == Full);
  assign rx_empty = (rx_cnt_q == '0);

  // A same-cycle pop frees the slot, so a push into a full TXQ is still accepted.
  assign tx_push = data_wr & (~tx_full | tx_pop);
  assign ovf_set = data_wr & tx_full & ~tx_pop;
  assign rx_pop  = data_rd & ~rx_empty;

  assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
  assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  assign ovf_d    = ovf_set ? 1'b1 : (status_wr ? 1'b0 : ovf_q);
  assign cfg_pending_d = div_wr ? 1'b1 : (cfg_clear ? 1'b0 : cfg_pending_q);

  always_comb begin
    clk_div_d = clk_div_q;
    if (div_wr && cpu_bus.write_mask[1]) clk_div_d[31:16] = cpu_bus.write_value[31:16];
    if (div_wr && cpu_bus.write_mask[0]) clk_div_d[15:0]  = cpu_bus.write_value[15:0];
  end

  always_comb begin
    rd_data = '0;
    if (cpu_bus.sel) begin
      unique case (reg_sel)
        2'b00: begin
          rd_data[16 +: CW] = rx_cnt_q;
          rd_data[8 +: CW]  = tx_cnt_q;
          rd_data[3]        = ovf_q;
          rd_data[1]        = ~rx_empty;
          rd_data[0]        = ~tx_full;
        end
        2'b01:   rd_data = rx_empty ? {48'hFFFF_FFFF_FFFF, 16'h0}
                                    : {48'h0, rxq_mem_q[rx_rptr_q]};
        2'b10:   rd_data = {32'h0, clk_div_q};
        default: rd_data = '0;
      endcase
    end
  end

  assign cpu_bus.read_value = rd_data;

  // RX/TX targets are only chosen when the FIFO can take/give a word, and only
  // the CPU touches the other end meanwhile, so the condition still holds there.
  always_comb begin
    state_d   = state_q;
    u_addr    = '0;
    u_sel     = 1'b0;
    u_read    = 1'b0;
    u_mask    = '0;
    u_val     = '0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    cfg_clear = 1'b0;
    case (state_q)
      StIdle: state_d = (cfg_pending_q || div_wr) ? StCfg : StPoll;
      StCfg: begin
        u_sel     = 1'b1;
        u_mask    = 4'b0011;
        u_val     = {32'h0, clk_div_q};
        cfg_clear = 1'b1;
        state_d   = StIdle;
      end
      StPoll: begin
        u_sel  = 1'b1;
        u_addr = 64'h4;
        if (uart_bus.read_value[1] && !rx_full)       state_d = StRx;
        else if (uart_bus.read_value[0] && !tx_empty) state_d = StTx;
        else                                          state_d = StIdle;
      end
      StRx: begin
        u_sel   = 1'b1;
        u_addr  = 64'h8;
        u_read  = 1'b1;
        rx_push = 1'b1;
        state_d = StIdle;
      end
      StTx: begin
        u_sel   = 1'b1;
        u_addr  = 64'h8;
        u_mask  = 4'b0001;
        u_val   = {48'h0, txq_mem_q[tx_rptr_q]};
        tx_pop  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign uart_bus.address     = u_addr;
  assign uart_bus.sel         = u_sel;
  assign uart_bus.read        = u_read;
  assign uart_bus.write_mask  = u_mask;
  assign uart_bus.write_value = u_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      tx_cnt_q      <= '0;
      rx_cnt_q      <= '0;
      ovf_q         <= 1'b0;
      cfg_pending_q <= 1'b0;
      clk_div_q     <= '0;
    end else begin
      state_q       <= state_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      ovf_q         <= ovf_d;
      cfg_pending_q <= cfg_pending_d;
      clk_div_q     <= clk_div_d;
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
      if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && tx_push) txq_mem_q[tx_wptr_q] <= cpu_bus.write_value[15:0];
    if (!reset && rx_push) rxq_mem_q[rx_wptr_q] <= uart_bus.read_value[15:0];
  end

  logic unused_bits;
  assign unused_bits = ^{cpu_bus.address[63:4], cpu_bus.address[1:0], cpu_bus.write_mask[3:2],
                         cpu_bus.write_value[63:32], uart_bus.read_value[63:16]};
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a small UART register model on the master bus.
module tb_uart_fifo_bridge;
  localparam int unsigned DEPTH = 16;
  localparam logic [63:0] Empty = 64'hFFFF_FFFF_FFFF_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  uart_fifo_bridge_if cpu_if ();
  uart_fifo_bridge_if uart_if ();

  uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_bus  (cpu_if.slave),
    .uart_bus (uart_if.master)
  );

  always #5 clk = ~clk;

  // UART model: tx_ready under test control, rx words handed out one per DATA read.
  logic        tx_ready = 1'b0;
  int          rx_given = 0;
  int          rx_taken = 0;
  logic [15:0] rx_base = '0;
  logic        rx_hit = 1'b0;

  always_comb begin
    uart_if.read_value = '0;
    if (uart_if.sel && uart_if.address == 64'h4)
      uart_if.read_value = {62'h0, (rx_given > rx_taken), tx_ready};
    else if (uart_if.sel && uart_if.address == 64'h8)
      uart_if.read_value = {48'h0, rx_base + rx_taken[15:0]};
  end

  logic [63:0] wr_addr[$];
  logic [63:0] wr_val[$];
  logic [3:0]  wr_mask[$];
  int          wr_cyc[$];
  int          rx_cyc[$];

  always @(negedge clk) begin
    rx_hit = uart_if.sel && uart_if.read && uart_if.address == 64'h8;
    if (rx_hit) rx_cyc.push_back(cyc);
    if (uart_if.sel && uart_if.write_mask != 4'b0) begin
      wr_addr.push_back(uart_if.address);
      wr_val.push_back(uart_if.write_value);
      wr_mask.push_back(uart_if.write_mask);
      wr_cyc.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_hit) rx_taken <= rx_taken + 1;
  end

  task automatic cpu_idle();
    cpu_if.address     = '0;
    cpu_if.sel         = 1'b0;
    cpu_if.read        = 1'b0;
    cpu_if.write_mask  = '0;
    cpu_if.write_value = '0;
  endtask

  task automatic cpu_write(input logic [63:0] a, input logic [3:0] m, input logic [63:0] v);
    @(negedge clk);
    cpu_if.address     = a;
    cpu_if.sel         = 1'b1;
    cpu_if.read        = 1'b0;
    cpu_if.write_mask  = m;
    cpu_if.write_value = v;
    @(posedge clk);
    #1 cpu_idle();
  endtask

  task automatic cpu_read(input logic [63:0] a, input logic pop, output logic [63:0] v);
    @(negedge clk);
    cpu_if.address = a;
    cpu_if.sel     = 1'b1;
    cpu_if.read    = pop;
    #1 v = cpu_if.read_value;
    @(posedge clk);
    #1 cpu_idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    reset = 1'b1;
    cpu_idle();
    wait_cycles(3);
    checks++;
    if (uart_if.sel !== 1'b0 || uart_if.write_mask !== 4'b0 || uart_if.address !== 64'h0 ||
        uart_if.write_value !== 64'h0 || uart_if.read !== 1'b0) begin
      errors++;
      $display("FAIL reset_uart_outputs: got sel=%b mask=%h addr=%h want all zero",
               uart_if.sel, uart_if.write_mask, uart_if.address);
    end
    @(negedge clk) reset = 1'b0;
    checks++;
    if (cpu_if.read_value !== 64'h0) begin
      errors++; $display("FAIL idle_read_zero: got %h want 0", cpu_if.read_value);
    end
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1) begin errors++; $display("FAIL reset_status: got %h want %h", v, 64'h1); end
    cpu_read(64'h4, 1'b1, v);
    checks++;
    if (v !== Empty) begin errors++; $display("FAIL reset_data: got %h want %h", v, Empty); end
    cpu_read(64'h8, 1'b0, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL reset_clkdiv: got %h want 0", v); end
    cpu_read(64'hC, 1'b0, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL reserved_read: got %h want 0", v); end
  endtask

  task automatic test_cfg();
    logic [63:0] v;
    int n0, w, lat;
    n0 = wr_val.size();
    cpu_write(64'h8, 4'b0011, 64'h64);
    w = cyc;
    wait_cycles(12);
    checks++;
    if (wr_val.size() != n0 + 1) begin
      errors++; $display("FAIL cfg_count: got %0d want 1", wr_val.size() - n0);
    end else begin
      lat = wr_cyc[n0] - w;
      checks++;
      if (wr_addr[n0] !== 64'h0 || wr_val[n0] !== 64'h64 || wr_mask[n0] !== 4'b0011) begin
        errors++;
        $display("FAIL cfg_access: got addr=%h val=%h mask=%h want 0/64/3",
                 wr_addr[n0], wr_val[n0], wr_mask[n0]);
      end
      checks++;
      if (lat < 0 || lat > 1) begin errors++; $display("FAIL cfg_latency: got %0d want <=1", lat); end
    end
    cpu_read(64'h8, 1'b0, v);
    checks++;
    if (v !== 64'h64) begin errors++; $display("FAIL clkdiv_read: got %h want 64", v); end
  endtask

  task automatic test_tx();
    logic [63:0] v;
    int n0;
    tx_ready = 1'b1;
    n0 = wr_val.size();
    cpu_write(64'h4, 4'b0001, 64'h41);
    cpu_write(64'h4, 4'b0001, 64'h42);
    for (int i = 0; i < 40 && wr_val.size() < n0 + 2; i++) @(posedge clk);
    wait_cycles(4);
    checks++;
    if (wr_val.size() != n0 + 2) begin
      errors++; $display("FAIL tx_count: got %0d want 2", wr_val.size() - n0);
    end else begin
      checks++;
      if (wr_addr[n0] !== 64'h8 || wr_val[n0] !== 64'h41 || wr_mask[n0] !== 4'b0001) begin
        errors++; $display("FAIL tx_first: got addr=%h val=%h want 8/41", wr_addr[n0], wr_val[n0]);
      end
      checks++;
      if (wr_addr[n0+1] !== 64'h8 || wr_val[n0+1] !== 64'h42) begin
        errors++; $display("FAIL tx_second: got addr=%h val=%h want 8/42", wr_addr[n0+1],
                           wr_val[n0+1]);
      end
      checks++;
      if (wr_cyc[n0+1] - wr_cyc[n0] < 3) begin
        errors++; $display("FAIL tx_spacing: got %0d want >=3", wr_cyc[n0+1] - wr_cyc[n0]);
      end
    end
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1) begin errors++; $display("FAIL tx_status_after: got %h want 1", v); end
  endtask

  task automatic test_overflow();
    logic [63:0] v;
    int n0;
    tx_ready = 1'b0;
    wait_cycles(3);
    for (int i = 0; i <= DEPTH; i++) cpu_write(64'h4, 4'b0001, 64'h100 + 64'(i));
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1008) begin errors++; $display("FAIL ovf_status: got %h want 1008", v); end
    cpu_write(64'h0, 4'b0001, 64'h0);
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1000) begin errors++; $display("FAIL ovf_clear: got %h want 1000", v); end
    n0 = wr_val.size();
    tx_ready = 1'b1;
    for (int i = 0; i < 120 && wr_val.size() < n0 + DEPTH; i++) @(posedge clk);
    wait_cycles(10);
    checks++;
    if (wr_val.size() != n0 + DEPTH) begin
      errors++; $display("FAIL drain_count: got %0d want %0d", wr_val.size() - n0, DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (wr_val[n0+i] !== 64'h100 + 64'(i)) begin
          errors++; $display("FAIL drain_word%0d: got %h want %h", i, wr_val[n0+i],
                             64'h100 + 64'(i));
        end
      end
    end
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1) begin errors++; $display("FAIL drain_status: got %h want 1", v); end
  endtask

  task automatic test_rx();
    logic [63:0] v;
    rx_base = 16'h1234 - rx_taken[15:0];
    rx_given++;
    for (int i = 0; i < 30 && rx_taken < rx_given; i++) @(posedge clk);
    wait_cycles(3);
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1_0003) begin errors++; $display("FAIL rx_status: got %h want 10003", v); end
    cpu_read(64'h4, 1'b1, v);
    checks++;
    if (v !== 64'h1234) begin errors++; $display("FAIL rx_data: got %h want 1234", v); end
    cpu_read(64'h4, 1'b1, v);
    checks++;
    if (v !== Empty) begin errors++; $display("FAIL rx_empty_read: got %h want %h", v, Empty); end
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1) begin errors++; $display("FAIL rx_status_after: got %h want 1", v); end
  endtask

  task automatic test_rx_full();
    logic [63:0] v;
    int t0;
    t0 = rx_taken;
    rx_base = 16'h2000 - t0[15:0];
    rx_given += DEPTH + 2;
    for (int i = 0; i < 150 && rx_taken - t0 < DEPTH; i++) @(posedge clk);
    wait_cycles(12);
    checks++;
    if (rx_taken - t0 != DEPTH) begin
      errors++; $display("FAIL rx_held: got %0d taken want %0d", rx_taken - t0, DEPTH);
    end
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h10_0003) begin errors++; $display("FAIL rx_full_status: got %h want 100003", v); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      cpu_read(64'h4, 1'b1, v);
      checks++;
      if (v !== 64'h2000 + 64'(i)) begin
        errors++; $display("FAIL rx_order%0d: got %h want %h", i, v, 64'h2000 + 64'(i));
      end
      wait_cycles(4);
    end
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1 || rx_taken != rx_given) begin
      errors++; $display("FAIL rx_full_drained: got %h taken=%0d want 1 taken=%0d", v, rx_taken,
                         rx_given);
    end
  endtask

  task automatic test_priority();
    logic [63:0] v;
    int n0, m0;
    tx_ready = 1'b0;
    wait_cycles(3);
    cpu_write(64'h4, 4'b0001, 64'h55);
    n0 = wr_val.size();
    m0 = rx_cyc.size();
    rx_base = 16'h0077 - rx_taken[15:0];
    rx_given++;
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && (wr_val.size() <= n0 || rx_cyc.size() <= m0); i++) @(posedge clk);
    wait_cycles(2);
    checks++;
    if (wr_val.size() <= n0 || rx_cyc.size() <= m0) begin
      errors++; $display("FAIL prio_timeout: got tx=%0d rx=%0d want 1/1", wr_val.size() - n0,
                         rx_cyc.size() - m0);
    end else begin
      checks++;
      if (rx_cyc[m0] >= wr_cyc[n0]) begin
        errors++; $display("FAIL prio_order: got rx@%0d tx@%0d want rx first", rx_cyc[m0],
                           wr_cyc[n0]);
      end
      checks++;
      if (wr_val[n0] !== 64'h55) begin errors++; $display("FAIL prio_tx: got %h want 55", wr_val[n0]); end
    end
    cpu_read(64'h4, 1'b1, v);
    checks++;
    if (v !== 64'h77) begin errors++; $display("FAIL prio_rx: got %h want 77", v); end
  endtask

  task automatic test_reset_mid_tx();
    logic [63:0] v;
    logic hit;
    int n0;
    tx_ready = 1'b0;
    wait_cycles(3);
    for (int i = 0; i < 3; i++) cpu_write(64'h4, 4'b0001, 64'h61 + 64'(i));
    n0 = wr_val.size();
    tx_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      hit = uart_if.sel && uart_if.write_mask == 4'b0001;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midtx_timeout: got no TX access want one"); end
    reset              = 1'b1;
    cpu_if.address     = 64'h4;
    cpu_if.sel         = 1'b1;
    cpu_if.read        = 1'b0;
    cpu_if.write_mask  = 4'b0001;
    cpu_if.write_value = 64'h99;
    @(posedge clk);
    #1;
    checks++;
    if (uart_if.sel !== 1'b0 || uart_if.write_mask !== 4'b0 || uart_if.address !== 64'h0 ||
        uart_if.write_value !== 64'h0) begin
      errors++; $display("FAIL midtx_outputs: got sel=%b mask=%h val=%h want zero", uart_if.sel,
                         uart_if.write_mask, uart_if.write_value);
    end
    @(negedge clk);
    reset = 1'b0;
    cpu_idle();
    wait_cycles(12);
    cpu_read(64'h0, 1'b0, v);
    checks++;
    if (v !== 64'h1) begin errors++; $display("FAIL midtx_status: got %h want 1", v); end
    cpu_read(64'h8, 1'b0, v);
    checks++;
    if (v !== 64'h0) begin errors++; $display("FAIL midtx_clkdiv: got %h want 0", v); end
    checks++;
    if (wr_val.size() != n0 + 1) begin
      errors++; $display("FAIL midtx_discard: got %0d writes want 1", wr_val.size() - n0);
    end
  endtask

  initial begin
    cpu_idle();
    test_reset();
    test_cfg();
    test_tx();
    test_overflow();
    test_rx();
    test_rx_full();
    test_priority();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
